// File: rtl/mux_arbiter.sv
// Three-source round-robin arbiter driving the select and payload inputs of a
// downstream mux; each grant owns its select line for HOLD cycles.
module mux_arbiter #(
    parameter int HOLD = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req1,
    input  logic       req2,
    input  logic       req3,
    input  logic [3:0] data1,
    input  logic [3:0] data2,
    input  logic [3:0] data3,
    output logic       gnt1,
    output logic       gnt2,
    output logic       gnt3,
    output logic       sel1,
    output logic       sel2,
    output logic       sel3,
    output logic [3:0] ip1,
    output logic [3:0] ip2,
    output logic [3:0] ip3
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state_reg;
    logic [1:0] ptr_reg;
    logic [3:0] cnt_reg;
    logic       armed_reg;
    logic [2:0] gnt_reg;
    logic [2:0] sel_reg;
    logic [3:0] ip_reg [3];

    logic [2:0] req_vec;
    logic [3:0] data_vec [3];
    logic [2:0] elig;
    logic       win_valid;
    logic [1:0] win_idx;
    logic       hold_done;
    logic       grant_fire;

    // Zero-based index of the source reached 'off' steps after pointer ptr (1..3).
    function automatic logic [1:0] rr_idx(input logic [1:0] ptr, input int off);
        int t;
        t = (int'(ptr) - 1 + off) % 3;
        return 2'(t);
    endfunction

    assign req_vec     = {req3, req2, req1};
    assign data_vec[0] = data1;
    assign data_vec[1] = data2;
    assign data_vec[2] = data3;

    // A source still holding req while its gnt pulse is out must not win again.
    assign elig = req_vec & ~gnt_reg;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = 2'd0;
        for (int off = 3; off >= 1; off--) begin
            if (elig[rr_idx(ptr_reg, off)]) begin
                win_valid = 1'b1;
                win_idx   = rr_idx(ptr_reg, off);
            end
        end
    end

    assign hold_done  = (state_reg == IDLE) || (cnt_reg == HOLD_LAST);
    assign grant_fire = armed_reg && hold_done && win_valid;

    // armed_reg keeps the first edge after reset release grant-free.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            ptr_reg   <= 2'd3;
            cnt_reg   <= 4'd0;
            armed_reg <= 1'b0;
            gnt_reg   <= 3'b000;
            sel_reg   <= 3'b000;
        end else begin
            armed_reg <= 1'b1;
            gnt_reg   <= 3'b000;
            if (grant_fire) begin
                state_reg <= BUSY;
                gnt_reg   <= 3'b001 << win_idx;
                sel_reg   <= 3'b001 << win_idx;
                cnt_reg   <= 4'd0;
                ptr_reg   <= win_idx + 2'd1;
            end else if (state_reg == BUSY && cnt_reg != HOLD_LAST) begin
                cnt_reg <= cnt_reg + 4'd1;
            end else begin
                state_reg <= IDLE;
                sel_reg   <= 3'b000;
                cnt_reg   <= 4'd0;
            end
        end
    end

    // Payload registers only load on their own grant edge.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ip
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    ip_reg[gi] <= 4'h0;
                end else if (grant_fire && win_idx == 2'(gi)) begin
                    ip_reg[gi] <= data_vec[gi];
                end
            end
        end
    endgenerate

    assign gnt1 = gnt_reg[0];
    assign gnt2 = gnt_reg[1];
    assign gnt3 = gnt_reg[2];
    assign sel1 = sel_reg[0];
    assign sel2 = sel_reg[1];
    assign sel3 = sel_reg[2];
    assign ip1  = ip_reg[0];
    assign ip2  = ip_reg[1];
    assign ip3  = ip_reg[2];

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: HOLD=2 and HOLD=1 instances, each feeding a registered
// downstream mux; vector table, directed corner sequences, then random traffic.
module tb_mux_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_n = 1'b0;
    logic [2:0] req_v  [2];
    logic [3:0] data_v [2][3];
    wire  [2:0] gnt_v  [2];
    wire  [2:0] sel_v  [2];
    wire  [3:0] ip_v   [2][3];
    wire  [3:0] mux_op_v [2];

    int checks   = 0;
    int failures = 0;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            logic       g1, g2, g3, s1, s2, s3;
            logic [3:0] i1, i2, i3;
            logic [3:0] mux_op;
            mux_arbiter #(.HOLD(gi == 0 ? 2 : 1)) u_dut (
                .clock   (clock),
                .reset_n (reset_n),
                .req1    (req_v[gi][0]),
                .req2    (req_v[gi][1]),
                .req3    (req_v[gi][2]),
                .data1   (data_v[gi][0]),
                .data2   (data_v[gi][1]),
                .data3   (data_v[gi][2]),
                .gnt1    (g1),
                .gnt2    (g2),
                .gnt3    (g3),
                .sel1    (s1),
                .sel2    (s2),
                .sel3    (s3),
                .ip1     (i1),
                .ip2     (i2),
                .ip3     (i3)
            );
            assign gnt_v[gi]   = {g3, g2, g1};
            assign sel_v[gi]   = {s3, s2, s1};
            assign ip_v[gi][0] = i1;
            assign ip_v[gi][1] = i2;
            assign ip_v[gi][2] = i3;
            // downstream priority mux with registered output
            always @(posedge clock) mux_op <= s1 ? i1 : s2 ? i2 : s3 ? i3 : 4'h0;
            assign mux_op_v[gi] = mux_op;
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 3'b000;
            for (int s = 0; s < 3; s++) data_v[i][s] = 4'h0;
        end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // ---------------- reference model (grant bookkeeping per instance) ----------
    int         hold_of [2] = '{2, 1};
    int         left    [2];
    int         owner   [2];
    int         last    [2];
    bit         armed   [2];
    logic [2:0] mgnt    [2];
    logic [3:0] mip     [2][3];
    bit         pend_flag [2];
    logic [3:0] pend_data [2];
    bit         due_flag  [2];
    logic [3:0] due_data  [2];

    task automatic model_reset(input int i);
        left[i] = 0; owner[i] = 0; last[i] = 3; armed[i] = 1'b0; mgnt[i] = 3'b000;
        pend_flag[i] = 1'b0; due_flag[i] = 1'b0;
        for (int s = 0; s < 3; s++) mip[i][s] = 4'h0;
    endtask

    task automatic model_step(input int i);
        logic [2:0] old_gnt;
        int k;
        due_flag[i]  = pend_flag[i];
        due_data[i]  = pend_data[i];
        pend_flag[i] = 1'b0;
        old_gnt = mgnt[i];
        mgnt[i] = 3'b000;
        if (!armed[i]) begin
            armed[i] = 1'b1;
            return;
        end
        if (left[i] > 1) begin
            left[i]--;
            return;
        end
        k = 0;
        for (int n = 1; n <= 3 && k == 0; n++) begin
            int c;
            c = ((last[i] - 1 + n) % 3) + 1;
            if (req_v[i][c-1] && !old_gnt[c-1]) k = c;
        end
        if (k != 0) begin
            owner[i]     = k;
            left[i]      = hold_of[i];
            last[i]      = k;
            mgnt[i]      = 3'(1 << (k - 1));
            mip[i][k-1]  = data_v[i][k-1];
            pend_flag[i] = 1'b1;
            pend_data[i] = data_v[i][k-1];
        end else begin
            owner[i] = 0;
            left[i]  = 0;
        end
    endtask

    function automatic logic [2:0] model_sel(input int i);
        return (owner[i] == 0) ? 3'b000 : 3'(1 << (owner[i] - 1));
    endfunction

    // ---------------- vector table for instance 0 (HOLD=2) ----------------------
    typedef struct {
        logic [2:0] req;
        logic [3:0] d1, d2, d3;
        logic [2:0] gnt, sel;
        logic [3:0] i1, i2, i3;
    } vec_t;

    vec_t tbl [13];
    bit   linger [2][3];

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        // contention from reset: order 1,2,3,1 back-to-back, two cycles each
        tbl[0]  = '{3'b111, 4'h1, 4'h2, 4'h3, 3'b000, 3'b000, 4'h0, 4'h0, 4'h0};
        tbl[1]  = '{3'b111, 4'h1, 4'h2, 4'h3, 3'b001, 3'b001, 4'h1, 4'h0, 4'h0};
        tbl[2]  = '{3'b111, 4'h1, 4'h2, 4'h3, 3'b000, 3'b001, 4'h1, 4'h0, 4'h0};
        tbl[3]  = '{3'b111, 4'h1, 4'h2, 4'h3, 3'b010, 3'b010, 4'h1, 4'h2, 4'h0};
        tbl[4]  = '{3'b111, 4'h1, 4'h2, 4'h3, 3'b000, 3'b010, 4'h1, 4'h2, 4'h0};
        tbl[5]  = '{3'b111, 4'h1, 4'h2, 4'h3, 3'b100, 3'b100, 4'h1, 4'h2, 4'h3};
        tbl[6]  = '{3'b111, 4'h1, 4'h2, 4'h3, 3'b000, 3'b100, 4'h1, 4'h2, 4'h3};
        tbl[7]  = '{3'b111, 4'h1, 4'h2, 4'h3, 3'b001, 3'b001, 4'h1, 4'h2, 4'h3};
        tbl[8]  = '{3'b000, 4'h1, 4'h2, 4'h3, 3'b000, 3'b001, 4'h1, 4'h2, 4'h3};
        tbl[9]  = '{3'b000, 4'h1, 4'h2, 4'h3, 3'b000, 3'b000, 4'h1, 4'h2, 4'h3};
        // single request from source 2; other data changes must not be sampled
        tbl[10] = '{3'b010, 4'hF, 4'hA, 4'hF, 3'b010, 3'b010, 4'h1, 4'hA, 4'h3};
        tbl[11] = '{3'b000, 4'hF, 4'hA, 4'hF, 3'b000, 3'b010, 4'h1, 4'hA, 4'h3};
        tbl[12] = '{3'b000, 4'hF, 4'hA, 4'hF, 3'b000, 3'b000, 4'h1, 4'hA, 4'h3};

        for (int i = 0; i < 2; i++) begin
            req_v[i] = 3'b000;
            for (int s = 0; s < 3; s++) data_v[i][s] = 4'h0;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_gnt%0d", i), 32'(gnt_v[i]), 32'd0);
            chk($sformatf("reset_sel%0d", i), 32'(sel_v[i]), 32'd0);
            chk($sformatf("reset_ip%0d", i), {20'd0, ip_v[i][0], ip_v[i][1], ip_v[i][2]}, 32'd0);
        end
        do_reset();

        for (int r = 0; r < 13; r++) begin
            req_v[0]     = tbl[r].req;
            data_v[0][0] = tbl[r].d1;
            data_v[0][1] = tbl[r].d2;
            data_v[0][2] = tbl[r].d3;
            step();
            $display("vec %0d req=%b gnt=%b sel=%b ip=%h/%h/%h", r, tbl[r].req,
                     gnt_v[0], sel_v[0], ip_v[0][0], ip_v[0][1], ip_v[0][2]);
            chk($sformatf("vec%0d_gnt", r), 32'(gnt_v[0]), 32'(tbl[r].gnt));
            chk($sformatf("vec%0d_sel", r), 32'(sel_v[0]), 32'(tbl[r].sel));
            chk($sformatf("vec%0d_ip", r), {20'd0, ip_v[0][0], ip_v[0][1], ip_v[0][2]},
                {20'd0, tbl[r].i1, tbl[r].i2, tbl[r].i3});
        end

        // HOLD=1: req1 lingers one cycle after gnt1, pending req2 wins instead
        do_reset();
        req_v[1] = 3'b011; data_v[1][0] = 4'h5; data_v[1][1] = 4'h6;
        step();
        chk("h1_arm_gnt", 32'(gnt_v[1]), 32'd0);
        step();
        chk("h1_first_gnt", 32'(gnt_v[1]), 32'b001);
        step();
        chk("h1_no_double_gnt", 32'(gnt_v[1]), 32'b010);
        chk("h1_no_double_sel", 32'(sel_v[1]), 32'b010);
        chk("h1_ip2", 32'(ip_v[1][1]), 32'h6);
        req_v[1] = 3'b000;
        step();
        chk("h1_idle_sel", 32'(sel_v[1]), 32'd0);
        req_v[1] = 3'b001; data_v[1][0] = 4'h9;
        step();
        chk("h1_solo_gnt", 32'(gnt_v[1]), 32'b001);
        step();
        chk("h1_solo_linger_gnt", 32'(gnt_v[1]), 32'd0);
        chk("h1_solo_linger_sel", 32'(sel_v[1]), 32'd0);
        req_v[1] = 3'b000;

        // fairness: req1 held, req3 raised -> served right after current hold
        do_reset();
        req_v[0] = 3'b001; data_v[0][0] = 4'h1;
        step();
        step();
        chk("fair_gnt1", 32'(gnt_v[0]), 32'b001);
        req_v[0][2] = 1'b1; data_v[0][2] = 4'hC;
        n = 0;
        do begin
            step();
            n++;
        end while (gnt_v[0][2] !== 1'b1 && n < 8);
        chk("fair_gnt3_latency", 32'(n), 32'd2);
        chk("fair_ip3", 32'(ip_v[0][2]), 32'hC);
        req_v[0][2] = 1'b0;
        step();
        step();
        chk("fair_regrant1", 32'(gnt_v[0]), 32'b001);
        req_v[0] = 3'b100; data_v[0][2] = 4'h7;

        // reset during sel3 hold, then restart with source 1 first
        n = 0;
        do begin
            step();
            n++;
        end while (sel_v[0][2] !== 1'b1 && n < 8);
        chk("rst_sel3_seen", 32'(sel_v[0]), 32'b100);
        chk("rst_ip3_loaded", 32'(ip_v[0][2]), 32'h7);
        req_v[0] = 3'b000;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_sel", 32'(sel_v[0]), 32'd0);
        chk("rst_mid_ip3", 32'(ip_v[0][2]), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        req_v[0] = 3'b101; data_v[0][0] = 4'h1; data_v[0][2] = 4'h3;
        step();
        chk("rst_first_edge_gnt", 32'(gnt_v[0]), 32'd0);
        step();
        chk("rst_restart_gnt", 32'(gnt_v[0]), 32'b001);

        // random traffic against the reference model
        do_reset();
        for (int i = 0; i < 2; i++) begin
            model_reset(i);
            for (int s = 0; s < 3; s++) linger[i][s] = 1'b0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                for (int s = 0; s < 3; s++) begin
                    if (req_v[i][s]) begin
                        if (linger[i][s]) begin
                            req_v[i][s] = 1'b0;
                            linger[i][s] = 1'b0;
                        end else if (gnt_v[i][s]) begin
                            if ($urandom_range(3) == 0) linger[i][s] = 1'b1;
                            else req_v[i][s] = 1'b0;
                        end else if ($urandom_range(15) == 0) begin
                            req_v[i][s] = 1'b0;
                        end
                    end else if ($urandom_range(2) == 0) begin
                        req_v[i][s]  = 1'b1;
                        data_v[i][s] = 4'($urandom);
                    end
                end
            end
            @(posedge clock);
            model_step(0);
            model_step(1);
            @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                if (mgnt[i] != 3'b000)
                    $display("grant inst=%0d cyc=%0d src=%0d data=%h", i, cyc, owner[i],
                             mip[i][owner[i]-1]);
                chk($sformatf("rnd_gnt i%0d c%0d", i, cyc), 32'(gnt_v[i]), 32'(mgnt[i]));
                chk($sformatf("rnd_sel i%0d c%0d", i, cyc), 32'(sel_v[i]), 32'(model_sel(i)));
                chk($sformatf("rnd_ip i%0d c%0d", i, cyc),
                    {20'd0, ip_v[i][0], ip_v[i][1], ip_v[i][2]},
                    {20'd0, mip[i][0], mip[i][1], mip[i][2]});
                chk($sformatf("rnd_onehot i%0d c%0d", i, cyc), 32'($onehot0(sel_v[i])), 32'd1);
                if (due_flag[i])
                    chk($sformatf("rnd_mux i%0d c%0d", i, cyc), 32'(mux_op_v[i]), 32'(due_data[i]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter HOLD, default 2: number of cycles (1..15) a granted sel line stays asserted.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req1, req2, req3  input  1 each  request from source 1/2/3; held high until the matching gnt is seen.
REQ-005 data1, data2, data3  input  4 each  payload of source 1/2/3; valid while the matching req is high.
REQ-006 gnt1, gnt2, gnt3  output  1 each  one-cycle acceptance pulse to source 1/2/3.
REQ-007 sel1, sel2, sel3  output  1 each  select lines to the downstream mux; at most one high at any time.
REQ-008 ip1, ip2, ip3  output  4 each  registered payload to the downstream mux data inputs.

Function
REQ-009 The block SHALL implement states IDLE and BUSY, a 2-bit last-granted pointer (values 1..3), and a 4-bit hold counter.
REQ-010 All outputs SHALL be registered; the grant latency is exactly 1 cycle from the edge that samples req to the cycle in which gnt/sel/ip update.
REQ-011 Arbitration SHALL be round-robin: after granting source k, the search order is k+1, k+2, k (mod 3, sources numbered 1..3).
REQ-012 IDLE, any req high at an edge: go to BUSY, assert gnt_k and sel_k for the winner k, load ip_k <= data_k, clear the hold counter, set pointer <= k.
REQ-013 IDLE, no req: remain IDLE with all sel and gnt low.
REQ-014 gnt_k SHALL be high for exactly the first cycle of a grant; sel_k SHALL be high for exactly HOLD consecutive cycles.
REQ-015 BUSY, hold counter < HOLD-1: increment the counter and keep sel_k and ip_k unchanged.
REQ-016 BUSY, hold counter == HOLD-1, any eligible req: grant the next winner on that edge with no gap cycle (back-to-back).
REQ-017 BUSY, hold counter == HOLD-1, no eligible req: return to IDLE and clear all sel lines.
REQ-018 A source whose gnt is high in the current cycle SHALL be ineligible at that edge, so a req still high while gnt is high never produces a double grant.
REQ-019 With HOLD=1, consecutive grants SHALL still follow REQ-011 and REQ-018.
REQ-020 ip outputs of non-granted sources SHALL hold their last loaded value; data inputs SHALL be sampled only on a grant edge.
REQ-021 sel1/sel2/sel3 SHALL be one-hot or all-zero in every cycle, so the downstream priority mux never sees overlapping selects.
REQ-022 A req that drops before it is granted SHALL be ignored with no grant issued.

Reset
REQ-023 On reset_n low, asynchronously: state=IDLE, pointer=3 (source 1 first in order), hold counter=0, all gnt=0, all sel=0, ip1=ip2=ip3=4'h0.
REQ-024 Reset asserted mid-grant SHALL immediately drop sel and gnt; after release, arbitration SHALL restart from the source-1-first order.
REQ-025 The first grant after reset_n rises SHALL occur no earlier than the second rising edge after release.

Verification
REQ-026 Single request: req2=1, data2=4'hA, HOLD=2 -> next cycle gnt2=1, sel2=1, ip2=A; sel2 high for 2 cycles, then IDLE.
REQ-027 Contention from reset: req1=req2=req3=1 held, data=1/2/3 -> grant order 1,2,3,1, back-to-back, each sel high for 2 cycles, never two sel high at once.
REQ-028 Fairness: req1 held continuously, req3 pulsed until granted -> req3 granted immediately after the current source-1 hold, never starved.
REQ-029 HOLD=1: req1 stays high one cycle after gnt1 -> no second gnt1 on that edge (REQ-018); req2, if pending, is granted instead.
REQ-030 Reset mid-grant: assert reset_n=0 during sel3 hold -> sel3=0, ip3=0 within the same cycle; after release, req1=req3=1 -> source 1 granted first.
REQ-031 Run the bench with the downstream mux attached: every grant to source k SHALL produce mux_op==data_k one cycle after sel_k rises.
